// File: rtl/program_counter_if.sv
// Control/status bundle between instruction decode and the program counter.
// Widths follow WIDTH (address) and DEPTH (return-stack entries).
interface program_counter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  logic                     en;
  logic                     clr;
  logic                     load;
  logic                     inc;
  logic                     call;
  logic                     ret;
  logic [WIDTH-1:0]         in;
  logic [WIDTH-1:0]         out;
  logic                     wrap;
  logic [$clog2(DEPTH):0]   depth;
  logic                     stack_err;

  modport master (
    output en, clr, load, inc, call, ret, in,
    input  out, wrap, depth, stack_err
  );

  modport slave (
    input  en, clr, load, inc, call, ret, in,
    output out, wrap, depth, stack_err
  );
endinterface

// File: rtl/program_counter.sv
// Program counter with load/inc/clear and a DEPTH-entry return-address stack.
// PC_STACK_GUARD_EN: guarded stack (no wrap, sticky stack_err); default is a circular stack.
module program_counter #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clk,
  input logic              rst_n,
  program_counter_if.slave bus
);
  localparam int unsigned    PW   = $clog2(DEPTH);
  localparam int unsigned    DW   = PW + 1;
  localparam logic [DW-1:0]  FULL = DW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_dec;
  logic [DW-1:0]    cnt;
  logic             wrap_q;
  logic             do_clr, do_ret, do_call, do_load, do_inc;
  logic             empty, full, push;

  assign pc_inc  = pc + WIDTH'(1);
  assign ptr_dec = ptr - PW'(1);
  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL);

  always_comb begin
    do_clr  = 1'b0;
    do_ret  = 1'b0;
    do_call = 1'b0;
    do_load = 1'b0;
    do_inc  = 1'b0;
    if (bus.en) begin
      if (bus.clr)       do_clr  = 1'b1;
      else if (bus.ret)  do_ret  = 1'b1;
      else if (bus.call) do_call = 1'b1;
      else if (bus.load) do_load = 1'b1;
      else if (bus.inc)  do_inc  = 1'b1;
    end
  end

`ifdef PC_STACK_GUARD_EN
  assign push = do_call && !full;
`else
  assign push = do_call;
`endif

  // Stack storage needs no reset; rst_n gating keeps an in-flight call from landing.
  always_ff @(posedge clk) begin
    if (rst_n && push) stack[ptr] <= pc_inc;
  end

  // ptr is the write slot and wraps freely; cnt tracks how many entries are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_VALUE;
      ptr    <= '0;
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= do_inc && (pc == '1);
      if (do_clr) begin
        pc  <= RESET_VALUE;
        ptr <= '0;
        cnt <= '0;
      end else if (do_ret) begin
`ifdef PC_STACK_GUARD_EN
        if (!empty) begin
          pc  <= stack[ptr_dec];
          ptr <= ptr_dec;
          cnt <= cnt - DW'(1);
        end
`else
        pc  <= stack[ptr_dec];
        ptr <= ptr_dec;
        if (!empty) cnt <= cnt - DW'(1);
`endif
      end else if (do_call) begin
        pc <= bus.in;
        if (push) begin
          ptr <= ptr + PW'(1);
          if (!full) cnt <= cnt + DW'(1);
        end
      end else if (do_load) begin
        pc <= bus.in;
      end else if (do_inc) begin
        pc <= pc_inc;
      end
    end
  end

`ifdef PC_STACK_GUARD_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (do_clr) begin
      err_q <= 1'b0;
    end else if ((do_ret && empty) || (do_call && full)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.out   = pc;
  assign bus.wrap  = wrap_q;
  assign bus.depth = cnt;
endmodule
